// File: rtl/clint_timer_pkg.sv
// clint_timer_pkg: register offsets and address decode for the machine timer block
package clint_timer_pkg;
    localparam logic [15:0] MSIP_OFF        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_MT_LO,
        SEL_MT_HI
    } reg_sel_e;
    function automatic reg_sel_e decode_addr(input logic [15:0] addr);
        logic [15:0] w_word;
        w_word = addr & 16'hFFFC;
        return (w_word == MSIP_OFF)        ? SEL_MSIP   :
               (w_word == MTIMECMP_LO_OFF) ? SEL_CMP_LO :
               (w_word == MTIMECMP_HI_OFF) ? SEL_CMP_HI :
               (w_word == MTIME_LO_OFF)    ? SEL_MT_LO  :
               (w_word == MTIME_HI_OFF)    ? SEL_MT_HI  : SEL_NONE;
    endfunction
endpackage

// File: rtl/clint_timer_counter.sv
// clint_timer_counter: prescaler plus 64-bit mtime; a bus write to either half wins over the tick
module clint_timer_counter #(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_mtime
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] r_pre;
    logic [63:0]   r_mtime;
    logic          w_tick;
    assign w_tick  = (r_pre == PW'(PRESCALE - 1));
    assign o_mtime = r_mtime;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre   <= '0;
            r_mtime <= '0;
        end else if (i_we_lo || i_we_hi) begin
            r_pre <= '0;
            if (i_we_lo) r_mtime[31:0] <= i_wdata;
            if (i_we_hi) r_mtime[63:32] <= i_wdata;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            if (w_tick) r_mtime <= r_mtime + 64'd1;
        end
    end
endmodule

// File: rtl/clint_timer.sv
// clint_timer: memory-mapped mtime/mtimecmp/msip with valid/ready register port,
// driving level timer_irq and soft_irq into clint
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bus_valid,
    output logic            bus_ready,
    input  logic            bus_we,
    input  logic [15:0]     bus_addr,
    input  logic [XLEN-1:0] bus_wdata,
    output logic            bus_rvalid,
    input  logic            bus_rready,
    output logic [XLEN-1:0] bus_rdata,
    output logic            timer_irq,
    output logic            soft_irq
);
    logic [63:0]     r_cmp;
    logic            r_msip;
    logic            r_rvalid;
    logic [XLEN-1:0] r_rdata;
    logic            r_irq;
    logic [63:0]     w_mtime;
    reg_sel_e        w_sel;
    logic            w_wr;
    logic            w_rd;
    logic [XLEN-1:0] w_rd_data;
    assign w_sel      = decode_addr(bus_addr);
    assign bus_ready  = !r_rvalid || bus_rready;
    assign w_wr       = bus_valid && bus_ready && bus_we;
    assign w_rd       = bus_valid && bus_ready && !bus_we;
    assign bus_rvalid = r_rvalid;
    assign bus_rdata  = r_rdata;
    assign timer_irq  = r_irq;
    assign soft_irq   = r_msip;
    clint_timer_counter #(.PRESCALE(PRESCALE)) u_counter (
        .clk     (clk),
        .rst     (rst),
        .i_we_lo (w_wr && (w_sel == SEL_MT_LO)),
        .i_we_hi (w_wr && (w_sel == SEL_MT_HI)),
        .i_wdata (bus_wdata),
        .o_mtime (w_mtime)
    );
    always_comb begin
        w_rd_data = (w_sel == SEL_MSIP)   ? {{(XLEN-1){1'b0}}, r_msip} :
                    (w_sel == SEL_CMP_LO) ? r_cmp[31:0]   :
                    (w_sel == SEL_CMP_HI) ? r_cmp[63:32]  :
                    (w_sel == SEL_MT_LO)  ? w_mtime[31:0] :
                    (w_sel == SEL_MT_HI)  ? w_mtime[63:32] : '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmp    <= '1;
            r_msip   <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
        end else begin
            // compare uses current registers only, so no bus path reaches the irq
            r_irq <= (w_mtime >= r_cmp);
            if (w_wr && (w_sel == SEL_MSIP))   r_msip <= bus_wdata[0];
            if (w_wr && (w_sel == SEL_CMP_LO)) r_cmp[31:0] <= bus_wdata;
            if (w_wr && (w_sel == SEL_CMP_HI)) r_cmp[63:32] <= bus_wdata;
            if (w_rd) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (bus_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end
endmodule
